// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for the 5-stage core's elastic stage registers: packed stage
// payloads, their widths, and the per-cycle buffer operation encoding.
package pipe_stage_buf_pkg;

  localparam int PIPE_DEPTH_MAX = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

  // {push, pop} for one cycle, flush already folded out of push.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } buf_op_e;

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter used for the stage-buffer stall/flush statistics.
module sat_counter
  import pipe_stage_buf_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline stage register with flush, optional skid buffer,
// bubble zeroing and saturating stall/flush counters.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 2,
  parameter bit ZERO_BUBBLE = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;

  logic    push, pop, push_keep;
  logic    stall_inc, flush_inc;
  buf_op_e op;

  // Explicit wrap so DEPTH=3 never walks into the unused pointer code.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + 1'b1;
  endfunction

  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign push_keep = push & ~flush;
  assign op        = buf_op_e'({push_keep, pop});
  assign occupancy = count_q;

  generate
    if (DEPTH == 1) begin : g_single
      // A lone register can take a new payload in the same cycle it drains.
      assign in_ready = ~out_valid | out_ready;
    end else begin : g_skid
      logic in_ready_q, in_ready_d;

      always_comb begin
        in_ready_d = (count_d < DEPTH_C);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) in_ready_q <= 1'b1;
        else        in_ready_q <= in_ready_d;
      end

      assign in_ready = in_ready_q;
    end
  endgenerate

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_keep) mem_d[wr_ptr_q] = in_data;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          wr_ptr_d = ptr_next(wr_ptr_q);
          count_d  = count_q + 1'b1;
        end
        OP_POP: begin
          rd_ptr_d = ptr_next(rd_ptr_q);
          count_d  = count_q - 1'b1;
        end
        OP_BOTH: begin
          wr_ptr_d = ptr_next(wr_ptr_q);
          rd_ptr_d = ptr_next(rd_ptr_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // An all-zero word is a NOP bubble for the downstream stage.
  always_comb begin
    out_data = mem_q[rd_ptr_q];
    if (ZERO_BUBBLE && !out_valid) out_data = '0;
  end

  assign stall_inc = out_valid & ~out_ready & ~flush;
  assign flush_inc = flush & (count_q != '0);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule
